// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Producer side of the IF/ID interface. Owns the fetch PC, issues
//            in-order requests to instruction memory under a credit limit,
//            buffers responses in a small queue and presents the head entry
//            to the decode-stage pipeline register. A redirect flushes the
//            queue and drops every response of the old stream still in flight.
// Ports    : CLK, RESET (async, active high)
//            StallF, RedirectE, RedirectPC       - pipeline control
//            IMemReq, IMemAddr, IMemGnt          - request channel
//            IMemRValid, IMemRData               - in-order response channel
//            InstrF, PCF, ValidF                 - head of fetch queue
//            PerfFetched, PerfDropped            - only with FETCH_PERF_EN
// Config   : `define FETCH_PERF_EN adds dequeue / drop event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        StallF,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        ValidF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] PerfFetched,
  output logic [31:0] PerfDropped
`endif
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          PW      = $clog2(DEPTH);
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);
  localparam logic [31:0] C_NOP   = 32'h0000_0013;

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic [PW-1:0] r_q_head;
  logic [PW-1:0] r_q_tail;
  logic [PW-1:0] r_t_head;
  logic [PW-1:0] r_t_tail;

  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_tag     [DEPTH];

  logic [CW:0]   w_occupancy;
  logic          w_req;
  logic          w_xfer;
  logic          w_rsp;
  logic          w_enq;
  logic          w_drop;
  logic          w_deq;
  logic [CW-1:0] w_outst_next;

  // Queued plus outstanding never exceeds DEPTH, so the queue cannot overflow.
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_outst};
  assign w_req       = !RESET && (w_occupancy < C_DEPTH) && !RedirectE;
  assign w_xfer      = w_req && IMemGnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp  = IMemRValid && (r_outst != '0);
  // Responses of an abandoned stream, or arriving during a redirect, are dropped.
  assign w_enq  = w_rsp && (r_discard == '0) && !RedirectE;
  assign w_drop = w_rsp && !w_enq;
  assign w_deq  = ValidF && !StallF && !RedirectE;

  // w_xfer is 0 in a redirect cycle, so this is also the live in-flight
  // count after the edge that the discard counter must absorb.
  assign w_outst_next = r_outst + CW'(w_xfer) - CW'(w_rsp);

  assign IMemReq  = w_req;
  assign IMemAddr = r_fetch_pc;
  assign ValidF   = (r_count != '0);
  assign InstrF   = ValidF ? r_q_instr[r_q_head] : C_NOP;
  assign PCF      = ValidF ? r_q_pc[r_q_head]    : 32'h0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_q_head   <= '0;
      r_q_tail   <= '0;
      r_t_head   <= '0;
      r_t_tail   <= '0;
    end else begin
      r_outst <= w_outst_next;

      // Tag FIFO tracks every request in flight regardless of discard state.
      if (w_xfer) r_t_tail <= r_t_tail + 1'b1;
      if (w_rsp)  r_t_head <= r_t_head + 1'b1;

      if (RedirectE) begin
        r_fetch_pc <= RedirectPC;
        r_count    <= '0;
        r_q_head   <= '0;
        r_q_tail   <= '0;
        r_discard  <= w_outst_next;
      end else begin
        if (w_xfer) r_fetch_pc <= r_fetch_pc + 32'd4;
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        if (w_enq) r_q_tail <= r_q_tail + 1'b1;
        if (w_deq) r_q_head <= r_q_head + 1'b1;
        if (w_rsp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge CLK) begin
    if (w_xfer) r_tag[r_t_tail] <= r_fetch_pc;
    if (w_enq) begin
      r_q_instr[r_q_tail] <= IMemRData;
      r_q_pc[r_q_tail]    <= r_tag[r_t_head];
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] w_drop_inc;

  // Flushed queue entries and dropped responses can coincide in one cycle.
  assign w_drop_inc = (RedirectE ? 32'(r_count) : 32'd0) + 32'(w_drop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PerfFetched <= '0;
      PerfDropped <= '0;
    end else begin
      PerfFetched <= PerfFetched + 32'(w_deq);
      PerfDropped <= PerfDropped + w_drop_inc;
    end
  end
`endif

  a_no_orphan_rsp: assert property (@(posedge CLK) disable iff (RESET)
    !(IMemRValid && (r_outst == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A queue-based model of the
//            fetch stream (in-flight requests carry a "stale" mark instead of
//            counters) predicts every output each cycle; directed scenarios
//            add literal expectations, followed by a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        StallF, RedirectE, IMemGnt, IMemRValid;
  logic [31:0] RedirectPC, IMemRData;
  logic        IMemReq, ValidF;
  logic [31:0] IMemAddr, InstrF, PCF;
`ifdef FETCH_PERF_EN
  logic [31:0] PerfFetched, PerfDropped;
`endif

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .StallF(StallF), .RedirectE(RedirectE),
    .RedirectPC(RedirectPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemGnt(IMemGnt), .IMemRValid(IMemRValid), .IMemRData(IMemRData),
    .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF)
`ifdef FETCH_PERF_EN
    , .PerfFetched(PerfFetched), .PerfDropped(PerfDropped)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          ready;
  } fl_t;

  fl_t         infl[$];   // granted requests, in order
  logic [31:0] vis[$];    // PCs of queued instructions, head first
  logic [31:0] m_pc;
  int          m_fetched, m_dropped;
  int          cyc;
  int          lat_max;
  int          n_checks, n_fail;

  function automatic logic [31:0] mdata(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit gnt, input bit rv_allow, input bit stall,
                      input bit redir, input logic [31:0] rpc);
    bit rv, exp_req, deq;
    fl_t e;
    @(negedge CLK);
    rv = rv_allow && (infl.size() > 0) && (infl[0].ready <= cyc);
    StallF     = stall;
    RedirectE  = redir;
    RedirectPC = rpc;
    IMemGnt    = gnt;
    IMemRValid = rv;
    IMemRData  = rv ? mdata(infl[0].pc) : $urandom;
    exp_req = ((vis.size() + infl.size()) < DEPTH) && !redir;
    #1;
    chk("IMemReq",  {31'b0, IMemReq}, {31'b0, exp_req});
    chk("IMemAddr", IMemAddr, m_pc);
    chk("ValidF",   {31'b0, ValidF}, (vis.size() > 0) ? 32'd1 : 32'd0);
    chk("InstrF",   InstrF, (vis.size() > 0) ? mdata(vis[0]) : 32'h0000_0013);
    chk("PCF",      PCF,    (vis.size() > 0) ? vis[0] : 32'h0);
`ifdef FETCH_PERF_EN
    chk("PerfFetched", PerfFetched, 32'(m_fetched));
    chk("PerfDropped", PerfDropped, 32'(m_dropped));
`endif
    @(posedge CLK);
    deq = (vis.size() > 0) && !stall && !redir;
    if (deq) begin
      void'(vis.pop_front());
      m_fetched++;
    end
    if (rv) begin
      e = infl.pop_front();
      if (e.stale || redir) m_dropped++;
      else vis.push_back(e.pc);
    end
    if (redir) begin
      m_dropped += vis.size();
      vis.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = rpc;
    end else if (exp_req && gnt) begin
      e.pc = m_pc;
      e.stale = 1'b0;
      e.ready = cyc + $urandom_range(1, lat_max);
      infl.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (vis.size() == 0 && infl.size() == 0) break;
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    chk("drain_ValidF", {31'b0, ValidF}, 32'd0);
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 30; i++) begin
      if (vis.size() > 0) break;
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    chk(nm, {31'b0, ValidF}, 32'd1);
  endtask

  int base_drop;

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; lat_max = 1;
    m_pc = 32'h0; m_fetched = 0; m_dropped = 0;
    RESET = 1'b1; StallF = 0; RedirectE = 0; RedirectPC = 0;
    IMemGnt = 0; IMemRValid = 0; IMemRData = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_IMemReq", {31'b0, IMemReq}, 32'd0);
    chk("rst_ValidF",  {31'b0, ValidF},  32'd0);
    chk("rst_InstrF",  InstrF, 32'h0000_0013);
    chk("rst_PCF",     PCF,    32'h0);
    chk("rst_IMemAddr", IMemAddr, 32'h0);
    RESET = 1'b0;

    // 1: streaming, 1-cycle latency
    step(1, 1, 0, 0, 0);
    chk("s1_ValidF_c1", {31'b0, ValidF}, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("s1_ValidF_c2", {31'b0, ValidF}, 32'd1);
    chk("s1_PCF0",   PCF,    32'h0);
    chk("s1_Instr0", InstrF, 32'h1357_9BDF);
    step(1, 1, 0, 0, 0);
    chk("s1_PCF4",   PCF,    32'h4);
    chk("s1_Instr4", InstrF, 32'h1357_9BDB);
    step(1, 1, 0, 0, 0);
    chk("s1_PCF8",   PCF,    32'h8);

    // 2: stall six cycles, head stays at 0x8
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1, 0, 0);
      chk("s2_PCF_hold", PCF, 32'h8);
    end
    step(1, 1, 0, 0, 0);
    chk("s2_PCF_next", PCF, 32'hC);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);

    // 3: redirect with two grants outstanding
    drain();
    base_drop = m_dropped;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h100);
    chk("s3_ValidF_flush", {31'b0, ValidF}, 32'd0);
    wait_valid("s3_wait");
    chk("s3_PCF", PCF, 32'h100);
`ifdef FETCH_PERF_EN
    chk("s3_PerfDropped", PerfDropped, 32'(base_drop + 2));
    chk("s3_PerfFetched", PerfFetched, 32'(m_fetched));
`endif

    // 4: redirect coinciding with a response
    drain();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'h180);
    wait_valid("s4_wait");
    chk("s4_PCF", PCF, 32'h180);

    // 5: no grants, then redirect to 0x200
    drain();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h200);
    chk("s5_IMemAddr", IMemAddr, 32'h200);
    wait_valid("s5_wait");
    chk("s5_PCF",    PCF,    32'h200);
    chk("s5_InstrF", InstrF, 32'h1357_99DF);

    // randomized run
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom & 32'h0000_FFFC);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
